// File: rtl/scr1_pipe_vwb.sv
// Vector writeback assembler: packs LANES lane beats into one vector MPRF write.
// Scalar EXU writes share the port and always win. Optional: SCR1_VWB_HAZARD_EN.
module scr1_pipe_vwb #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_W-1:0]       cmd_rd_addr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_data,
  input  logic                    exu_w_req,
  input  logic [ADDR_W-1:0]       exu_rd_addr,
  input  logic [XLEN-1:0]         exu_rd_data,
  output logic                    mprf_w_req,
  output logic [ADDR_W-1:0]       mprf_rd_addr,
  output logic                    mprf_rd_is_vector,
  output logic [LANES*XLEN-1:0]   mprf_rd_data,
  output logic                    busy,
`ifdef SCR1_VWB_HAZARD_EN
  input  logic [ADDR_W-1:0]       rs1_addr,
  input  logic [ADDR_W-1:0]       rs2_addr,
  output logic                    hazard,
`endif
  output logic                    done
);

  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_COMMIT
  } state_t;

  state_t                       state_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [LANES-1:0][XLEN-1:0]   buf_q;
  logic [ADDR_W-1:0]            rd_q;
  logic                         done_q;
  logic                         commit_fire;

  // The commit retires only when the port is free and no flush kills it.
  assign commit_fire = (state_q == ST_COMMIT) && !exu_w_req && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_valid) begin
              rd_q    <= cmd_rd_addr;
              cnt_q   <= '0;
              state_q <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (in_valid) begin
              buf_q[cnt_q] <= in_data;
              if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                state_q <= ST_COMMIT;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          ST_COMMIT: begin
            if (!exu_w_req) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_FILL);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  // x0 destination still retires, but never reaches the register file.
  always_comb begin
    mprf_w_req        = 1'b0;
    mprf_rd_addr      = '0;
    mprf_rd_is_vector = 1'b0;
    mprf_rd_data      = '0;
    if (exu_w_req) begin
      mprf_w_req              = 1'b1;
      mprf_rd_addr            = exu_rd_addr;
      mprf_rd_data[XLEN-1:0]  = exu_rd_data;
    end else if (commit_fire && (rd_q != '0)) begin
      mprf_w_req        = 1'b1;
      mprf_rd_is_vector = 1'b1;
      mprf_rd_addr      = rd_q;
      mprf_rd_data      = buf_q;
    end
  end

`ifdef SCR1_VWB_HAZARD_EN
  assign hazard = busy && (rd_q != '0) && ((rs1_addr == rd_q) || (rs2_addr == rd_q));
`endif

endmodule

// File: doc/scr1_pipe_vwb.md
# scr1_pipe_vwb

Vector writeback assembler on the write side of the multi-port register file (MPRF). It accepts one vector writeback command plus a stream of `LANES` 32-bit lane beats from a multi-cycle producer (vector load, RLWE/NTT unit), packs them into one vector word, and issues a single vector MPRF write. It shares the MPRF write port with the EXU scalar writeback and gives the scalar write priority.

## Interface
- `LANES`, default 4: lanes per vector register, equal to the codebase `LANE` define.
- `XLEN`, default 32: lane width in bits.
- `ADDR_W`, default 5: MPRF address width.

- `clk`, in, 1: clock.
- `rst`, in, 1: reset. One clock; `rst` is asynchronous and active-high.
- `flush`, in, 1: synchronous abort of any pending vector writeback.
- `cmd_valid` / `cmd_ready`, in / out, 1 / 1: vector writeback command handshake.
- `cmd_rd_addr`, in, ADDR_W: destination vector register.
- `in_valid` / `in_ready`, in / out, 1 / 1: lane beat handshake.
- `in_data`, in, XLEN: lane beat data. Lane 0 arrives first.
- `exu_w_req`, in, 1: EXU scalar write request.
- `exu_rd_addr`, in, ADDR_W: EXU scalar write address.
- `exu_rd_data`, in, XLEN: EXU scalar write data.
- `mprf_w_req`, out, 1: write request to the MPRF.
- `mprf_rd_addr`, out, ADDR_W: write address to the MPRF.
- `mprf_rd_is_vector`, out, 1: selects a vector write (1) or scalar write (0).
- `mprf_rd_data`, out, LANES*XLEN: write data. Lane i occupies bits [i*XLEN +: XLEN].
- `busy`, out, 1: high in FILL or COMMIT.
- `done`, out, 1: one-cycle pulse when a vector writeback retires.

## Operation
- **IDLE**
  - `cmd_ready`=1 and `in_ready`=0.
  - On `cmd_valid`: latch `cmd_rd_addr`, clear the lane counter, go to FILL.
- **FILL**
  - `in_ready`=1.
  - Each accepted beat writes lane buffer[cnt] and increments `cnt`.
  - The beat with `cnt`==LANES-1 moves the FSM to COMMIT.
  - `cnt` is $clog2(LANES) bits and wraps to 0 on that beat.
- **COMMIT**
  - `in_ready`=0.
  - If `exu_w_req`=0: drive the vector write (`mprf_w_req`=1, `mprf_rd_is_vector`=1, latched address, buffer) and go to IDLE.
  - If `exu_w_req`=1: the scalar write passes through and COMMIT holds, with no cycle limit.
- **Scalar pass-through, every state**
  - When `exu_w_req`=1: `mprf_w_req`=1, `mprf_rd_is_vector`=0, `mprf_rd_addr`=`exu_rd_addr`.
  - `mprf_rd_data` = `exu_rd_data` in lane 0, other lanes zero.
  - The MPRF path is combinational.
- **Destination x0**
  - A command to x0 is still accepted and consumes all LANES beats.
  - In COMMIT the vector `mprf_w_req` is suppressed. The FSM returns to IDLE and `done` still pulses.
- **Abort**
  - `flush` in any state: go to IDLE and clear `cnt`. No vector write, no `done`.
  - `flush` has priority over a same-cycle commit.
- **Reset values**
  - State IDLE, `cnt`=0, buffer=0, latched address=0.
  - `done`=0, `busy`=0, `in_ready`=0, `cmd_ready`=1.
  - `mprf_w_req` follows `exu_w_req`.

## Timing
- Command accepted at cycle T. Beats are accepted from T+1 onward, one per cycle at most.
- With back-to-back beats, the last beat lands at T+LANES and the vector write at T+LANES+1, absent scalar conflict.
- `done` is registered: high the cycle after the vector write.
- A new command may be accepted in that same cycle, since the FSM is already IDLE.
- `in_valid` while `in_ready`=0 is ignored; the data is not captured.
- Gaps in `in_valid` stall FILL without losing `cnt`.
- Reset asserted mid-FILL or mid-COMMIT drops the operation immediately. No MPRF vector write occurs.

## Configuration
- `SCR1_VWB_HAZARD_EN` defined:
  - Adds inputs `rs1_addr` and `rs2_addr` (ADDR_W each) and output `hazard`.
  - `hazard` = `busy` && (latched rd != 0) && (`rs1_addr`==rd || `rs2_addr`==rd). It is combinational.
  - The EXU stalls on it.
- Macro undefined: these ports are absent. Operand ordering is the issue logic's responsibility.

## Test plan
- **Basic fill:** cmd rd=5, beats 0x11, 0x22, 0x33, 0x44 back-to-back -> one cycle with `mprf_w_req`=1, `is_vector`=1, addr 5, data {0x44,0x33,0x22,0x11} (lane 3..0) at T+5; `done` at T+6.
- **Scalar conflict:** reach COMMIT, hold `exu_w_req`=1 (addr 7, data 0xDEAD) for 3 cycles -> 3 scalar writes, lane 0 = 0xDEAD, `is_vector`=0. Vector write to rd occurs on cycle 4.
- **Bubbled beats:** `in_valid` toggling 1,0,0,1,0,1,1 -> buffer lanes correct, write after the 4th accepted beat. Beats presented in IDLE/COMMIT are ignored.
- **x0 destination:** cmd rd=0 plus 4 beats -> no vector `mprf_w_req`; `done` pulses; `cmd_ready` returns to 1.
- **Flush:** flush after 2 beats -> IDLE, no write, no `done`; the next command fills all 4 lanes fresh with no stale data. Reset mid-FILL -> all outputs at reset values.
- **Hazard (`SCR1_VWB_HAZARD_EN`):** busy with rd=9, `rs2_addr`=9 -> `hazard`=1. After `done`, `hazard`=0. With rd=0, `hazard` is never asserted.
